// File: rtl/ccode_unit.sv
// ----------------------------------------------------------------------------
// ccode_unit
//
// Condition-code unit. It holds the N/V/Z flag register, derives new flags
// from the ALU result, evaluates branch conditions, and keeps a small LIFO of
// saved flag values for interrupt entry and exit.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   stall             freezes every state update (flags, stack, branch_taken_q)
//   opcode, cond      instruction opcode and branch condition field
//   flag_we,flag_mask flag write enable and per-flag mask {N,V,Z}
//   alu_result        ALU output, the source of N and Z
//   alu_ovfl          ALU overflow, the source of V
//   push, pop         save / restore the flags on the stack
//   nvz               registered flags {N,V,Z}
//   cond_true         combinational branch condition result
//   branch_taken_q    cond_true registered one cycle (held while stalled)
//   stack_full/empty  stack occupancy flags, derived from the registered count
//   stack_err         one-cycle pulse after an illegal stack operation
// ----------------------------------------------------------------------------
module ccode_unit #(
    parameter int                DATA_W      = 16,
    parameter int                OPCODE_W    = 5,
    parameter logic [OPCODE_W-1:0] BRANCH_OP = 5'b00111,
    parameter int                STACK_DEPTH = 4,
    parameter bit                BYPASS      = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [2:0]          cond,
    input  logic                flag_we,
    input  logic [2:0]          flag_mask,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_ovfl,
    input  logic                push,
    input  logic                pop,
    output logic [2:0]          nvz,
    output logic                cond_true,
    output logic                branch_taken_q,
    output logic                stack_full,
    output logic                stack_empty,
    output logic                stack_err
);

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [2:0]       nvz_q, nvz_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic             taken_q, taken_d;
    logic [2:0]       stack_q [STACK_DEPTH];

    logic [2:0]       new_nvz;
    logic [2:0]       merged_nvz;
    logic [2:0]       eval_nvz;
    logic             full, empty;
    logic             push_ok, pop_ok, illegal_op;
    logic [IDX_W-1:0] push_idx, pop_idx;
    logic [CNT_W-1:0] count_m1;

    // Candidate flags from the current ALU result, merged under the mask
    // with the registered flags.
    assign new_nvz    = {alu_result[DATA_W-1], alu_ovfl, (alu_result == '0)};
    assign merged_nvz = (flag_mask & new_nvz) | (~flag_mask & nvz_q);

    // With the bypass enabled a branch sees flags written in the same cycle.
    assign eval_nvz = (BYPASS && flag_we) ? merged_nvz : nvz_q;

    always_comb begin
        cond_true = 1'b0;
        if (opcode == BRANCH_OP) begin
            unique case (cond)
                3'b000:  cond_true = ~eval_nvz[0];
                3'b001:  cond_true =  eval_nvz[0];
                3'b010:  cond_true = ~eval_nvz[0] & ~eval_nvz[2];
                3'b011:  cond_true =  eval_nvz[2];
                3'b100:  cond_true = ~eval_nvz[2];
                3'b101:  cond_true =  eval_nvz[2] | eval_nvz[0];
                3'b110:  cond_true =  eval_nvz[1];
                default: cond_true = 1'b1;
            endcase
        end
    end

    assign full  = (count_q == CNT_W'(STACK_DEPTH));
    assign empty = (count_q == '0);

    assign push_ok    = ~stall & push & ~pop & ~full;
    assign pop_ok     = ~stall & pop & ~push & ~empty;
    assign illegal_op = ~stall & ((push & pop) | (push & ~pop & full) |
                                  (pop & ~push & empty));

    assign count_m1 = count_q - CNT_W'(1);
    assign push_idx = count_q[IDX_W-1:0];
    assign pop_idx  = count_m1[IDX_W-1:0];

    always_comb begin
        nvz_d   = nvz_q;
        count_d = count_q;
        taken_d = taken_q;
        err_d   = illegal_op;
        if (!stall) begin
            taken_d = cond_true;
            // A legal pop wins over a same-cycle flag write; an ignored pop
            // (empty stack or collided with push) lets the write through.
            if (pop_ok) begin
                nvz_d   = stack_q[pop_idx];
                count_d = count_m1;
            end else if (flag_we) begin
                nvz_d = merged_nvz;
            end
            if (push_ok) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nvz_q   <= 3'b000;
            count_q <= '0;
            err_q   <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            nvz_q   <= nvz_d;
            count_q <= count_d;
            err_q   <= err_d;
            taken_q <= taken_d;
        end
    end

    // Stack storage needs no reset: entries are only read below count_q.
    // The pre-update flags are saved, so a same-cycle flag write is not stacked.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            stack_q[push_idx] <= nvz_q;
        end
    end

    assign nvz            = nvz_q;
    assign branch_taken_q = taken_q;
    assign stack_full     = full;
    assign stack_empty    = empty;
    assign stack_err      = err_q;

endmodule

// File: tb/tb_ccode_unit.sv
module tb_ccode_unit;

    localparam int         DEPTH = 4;
    localparam logic [4:0] BR    = 5'b00111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [4:0]  opcode;
    logic [2:0]  cond;
    logic        flag_we;
    logic [2:0]  flag_mask;
    logic [15:0] alu_result;
    logic        alu_ovfl;
    logic        push;
    logic        pop;

    logic [2:0] nvz0, nvz1;
    logic       ct0, ct1, bt0, bt1;
    logic       full0, full1, empty0, empty1, err0, err1;

    always #5 clk = ~clk;

    ccode_unit #(.DATA_W(16), .OPCODE_W(5), .BRANCH_OP(BR), .STACK_DEPTH(DEPTH), .BYPASS(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .opcode(opcode), .cond(cond),
        .flag_we(flag_we), .flag_mask(flag_mask), .alu_result(alu_result),
        .alu_ovfl(alu_ovfl), .push(push), .pop(pop), .nvz(nvz0), .cond_true(ct0),
        .branch_taken_q(bt0), .stack_full(full0), .stack_empty(empty0), .stack_err(err0)
    );

    ccode_unit #(.DATA_W(16), .OPCODE_W(5), .BRANCH_OP(BR), .STACK_DEPTH(DEPTH), .BYPASS(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .opcode(opcode), .cond(cond),
        .flag_we(flag_we), .flag_mask(flag_mask), .alu_result(alu_result),
        .alu_ovfl(alu_ovfl), .push(push), .pop(pop), .nvz(nvz1), .cond_true(ct1),
        .branch_taken_q(bt1), .stack_full(full1), .stack_empty(empty1), .stack_err(err1)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    logic [2:0] nvz_m;
    logic [2:0] stk_m [$];
    logic       err_m, bt0_m, bt1_m;
    logic       ct0_obs, ct1_obs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic eval_cond(input logic [2:0] f, input logic [4:0] op, input logic [2:0] c);
        logic n, v, z;
        n = f[2]; v = f[1]; z = f[0];
        if (op != BR) return 1'b0;
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        nvz_m = 3'b000;
        stk_m.delete();
        err_m = 1'b0;
        bt0_m = 1'b0;
        bt1_m = 1'b0;
    endtask

    task automatic check_state(input string sfx);
        chk({"nvz0", sfx}, 32'(nvz0), 32'(nvz_m));
        chk({"nvz1", sfx}, 32'(nvz1), 32'(nvz_m));
        chk({"full", sfx}, 32'(full0), 32'(stk_m.size() == DEPTH));
        chk({"empty", sfx}, 32'(empty0), 32'(stk_m.size() == 0));
        chk({"err", sfx}, 32'(err0), 32'(err_m));
        chk({"bt0", sfx}, 32'(bt0), 32'(bt0_m));
        chk({"bt1", sfx}, 32'(bt1), 32'(bt1_m));
        chk({"empty1", sfx}, 32'({full1, empty1, err1}), 32'({full0, empty0, err0}));
    endtask

    // Called just after a falling edge: apply inputs, check the combinational
    // result, advance one rising edge, update the model, check registers.
    task automatic cycle(input logic [4:0] op, input logic [2:0] c, input logic we,
                         input logic [2:0] m, input logic [15:0] r, input logic ov,
                         input logic pu, input logic po, input logic st);
        logic [2:0] newf, merged;
        logic       e0, e1;
        int         sz;
        opcode = op; cond = c; flag_we = we; flag_mask = m;
        alu_result = r; alu_ovfl = ov; push = pu; pop = po; stall = st;
        #1;
        newf   = {r[15], ov, (r == 16'd0)};
        merged = (m & newf) | (~m & nvz_m);
        e0 = eval_cond(nvz_m, op, c);
        e1 = eval_cond(we ? merged : nvz_m, op, c);
        ct0_obs = ct0;
        ct1_obs = ct1;
        chk("cond0", 32'(ct0), 32'(e0));
        chk("cond1", 32'(ct1), 32'(e1));
        @(posedge clk);
        sz = stk_m.size();
        if (st) begin
            err_m = 1'b0;
        end else begin
            bt0_m = e0;
            bt1_m = e1;
            err_m = (pu && po) || (pu && !po && sz == DEPTH) || (po && !pu && sz == 0);
            if (pu && !po && sz < DEPTH) stk_m.push_back(nvz_m);
            if (po && !pu && sz > 0) nvz_m = stk_m.pop_back();
            else if (we) nvz_m = merged;
        end
        @(negedge clk);
        check_state("");
    endtask

    task automatic setf(input logic [15:0] r, input logic ov);
        cycle(5'd0, 3'd0, 1'b1, 3'b111, r, ov, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; opcode = '0; cond = '0; flag_we = 1'b0;
        flag_mask = '0; alu_result = '0; alu_ovfl = 1'b0; push = 1'b0; pop = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_nvz", 32'(nvz0), 32'd0);
        chk("rst_empty", 32'(empty0), 32'd1);
        chk("rst_full", 32'(full0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_bt", 32'(bt0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero result sets Z; eq branch taken
        setf(16'h0000, 1'b0);
        chk("z_set", 32'(nvz0), 32'b001);
        cycle(BR, 3'b001, 1'b0, 3'b000, 16'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("eq_ct", 32'(ct0_obs), 32'd1);
        chk("eq_bt", 32'(bt0), 32'd1);

        // Masked write: V not written
        setf(16'h0001, 1'b0);
        cycle(5'd0, 3'd0, 1'b1, 3'b101, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mask_nvz", 32'(nvz0), 32'b100);
        cycle(BR, 3'b011, 1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lt", 32'(ct0_obs), 32'd1);
        cycle(BR, 3'b110, 1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ov", 32'(ct0_obs), 32'd0);
        cycle(BR, 3'b010, 1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("gt", 32'(ct0_obs), 32'd0);
        cycle(5'd3, 3'b111, 1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("nonbr", 32'(ct0_obs), 32'd0);

        // Bypass: write Z and branch eq in the same cycle
        setf(16'h0001, 1'b0);
        cycle(BR, 3'b001, 1'b1, 3'b111, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("byp1", 32'(ct1_obs), 32'd1);
        chk("byp0", 32'(ct0_obs), 32'd0);

        // Stack save / restore
        setf(16'h8000, 1'b0);
        cycle(5'd0, 3'd0, 1'b0, 3'b000, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        setf(16'h0000, 1'b0);
        cycle(5'd0, 3'd0, 1'b0, 3'b000, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        setf(16'h0001, 1'b1);
        chk("set010", 32'(nvz0), 32'b010);
        cycle(5'd0, 3'd0, 1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pop1", 32'(nvz0), 32'b001);
        cycle(5'd0, 3'd0, 1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pop2", 32'(nvz0), 32'b100);
        chk("pop2_empty", 32'(empty0), 32'd1);
        cycle(5'd0, 3'd0, 1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pop3_err", 32'(err0), 32'd1);
        chk("pop3_nvz", 32'(nvz0), 32'b100);
        cycle(5'd0, 3'd0, 1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("err_clr", 32'(err0), 32'd0);

        // Fill the stack and overflow it
        for (int i = 0; i < 5; i++) begin
            cycle(5'd0, 3'd0, 1'b0, 3'b000, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 3) chk("full4", 32'(full0), 32'd1);
            if (i == 4) chk("push5_err", 32'(err0), 32'd1);
        end
        cycle(5'd0, 3'd0, 1'b1, 3'b111, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("pushpop_err", 32'(err0), 32'd1);
        chk("pushpop_full", 32'(full0), 32'd1);

        // Stall freezes everything
        cycle(BR, 3'b111, 1'b1, 3'b111, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle(BR, 3'b111, 1'b1, 3'b111, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset mid-sequence
        push = 1'b1; stall = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_nvz", 32'(nvz0), 32'd0);
        chk("arst_empty", 32'(empty0), 32'd1);
        chk("arst_bt", 32'(bt0), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        push = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [4:0]  op;
            logic [15:0] r;
            op = ($urandom_range(0, 1) == 0) ? BR : 5'($urandom_range(0, 31));
            r  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            cycle(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), r, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 4) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
